// File: rtl/stream_conv2d.sv
// Streaming multi-channel 2D convolution over a K-row circular line buffer.
// Optional macro STREAM_CONV_SIGNED_EN selects two's-complement arithmetic.
module stream_conv2d #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K      = 2,
  parameter int unsigned CH     = 3,
  parameter int unsigned IMG    = 4,
  parameter int unsigned STRIDE = 2,
  parameter int unsigned ACC_W  = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [K*K*CH*DATA_W-1:0]     w_flat,
  output logic [ACC_W-1:0]             m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         frame_done
);

  localparam int unsigned W_W    = K * K * CH * DATA_W;
  localparam int unsigned CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned IMG_W  = (IMG > 1) ? $clog2(IMG) : 1;
  localparam int unsigned SLOT_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [IMG_W-1:0]    col_q, col_d;
  logic [IMG_W-1:0]    row_q, row_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [W_W-1:0]      w_q, w_d;
  logic [ACC_W-1:0]    m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   lb_q [K][IMG][CH];

  logic                accept_c;
  logic                last_ch_c, last_col_c, last_row_c, last_beat_c;
  logic                win_c;
  logic [W_W-1:0]      w_eff_c;
  logic [ACC_W-1:0]    sum_c;

  assign s_ready    = (state_q != DRAIN) && (!m_valid_q || m_ready);
  assign accept_c   = s_valid && s_ready;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign frame_done = done_q;

  assign last_ch_c   = (ch_q == CH_W'(CH - 1));
  assign last_col_c  = (col_q == IMG_W'(IMG - 1));
  assign last_row_c  = (row_q == IMG_W'(IMG - 1));
  assign last_beat_c = accept_c && last_ch_c && last_col_c && last_row_c;

  // The first beat of a frame must already see the weights it is about to capture
  assign w_eff_c = (state_q == IDLE) ? w_flat : w_q;

  // A window ends at its bottom-right pixel, last channel, on the stride grid
  always_comb begin
    win_c = accept_c && last_ch_c
         && (row_q >= IMG_W'(K - 1)) && (col_q >= IMG_W'(K - 1))
         && (((int'(row_q) + 1 - int'(K)) % int'(STRIDE)) == 0)
         && (((int'(col_q) + 1 - int'(K)) % int'(STRIDE)) == 0);
  end

  // Window dot product; the newest sample bypasses the line buffer
  always_comb begin
    logic [DATA_W-1:0]   px;
    logic [DATA_W-1:0]   wt;
    logic [SLOT_W-1:0]   sl;
    logic [IMG_W-1:0]    cidx;
`ifdef STREAM_CONV_SIGNED_EN
    logic signed [2*DATA_W-1:0] prod;
`else
    logic [2*DATA_W-1:0] prod;
`endif
    sum_c = '0;
    px    = '0;
    wt    = '0;
    sl    = '0;
    cidx  = '0;
    prod  = '0;
    for (int kr = 0; kr < int'(K); kr++) begin
      for (int kc = 0; kc < int'(K); kc++) begin
        for (int c = 0; c < int'(CH); c++) begin
          sl   = SLOT_W'((int'(slot_q) + 1 + kr) % int'(K));
          cidx = IMG_W'(int'(col_q) + 1 + kc - int'(K));
          if ((kr == int'(K) - 1) && (kc == int'(K) - 1) && (c == int'(CH) - 1))
            px = s_data;
          else
            px = lb_q[sl][cidx][c];
          wt = w_eff_c[((kr * int'(K) + kc) * int'(CH) + c) * int'(DATA_W) +: DATA_W];
`ifdef STREAM_CONV_SIGNED_EN
          prod = $signed({{DATA_W{px[DATA_W-1]}}, px}) * $signed({{DATA_W{wt[DATA_W-1]}}, wt});
`else
          prod = {DATA_W'(0), px} * {DATA_W'(0), wt};
`endif
          sum_c = sum_c + ACC_W'(prod);
        end
      end
    end
  end

  // Raster counters and circular row-slot pointer
  always_comb begin
    ch_d   = ch_q;
    col_d  = col_q;
    row_d  = row_q;
    slot_d = slot_q;
    w_d    = w_q;
    if (accept_c) begin
      if (state_q == IDLE) w_d = w_flat;
      if (!last_ch_c) begin
        ch_d = ch_q + CH_W'(1);
      end else begin
        ch_d = '0;
        if (!last_col_c) begin
          col_d = col_q + IMG_W'(1);
        end else begin
          col_d = '0;
          if (last_row_c) begin
            row_d  = '0;
            slot_d = '0;
          end else begin
            row_d  = row_q + IMG_W'(1);
            slot_d = (slot_q == SLOT_W'(K - 1)) ? '0 : slot_q + SLOT_W'(1);
          end
        end
      end
    end
  end

  // Frame FSM and output register
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = last_beat_c ? DRAIN : RUN;
      RUN:     if (last_beat_c) state_d = DRAIN;
      DRAIN: begin
        if (!m_valid_q || m_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (win_c) begin
      m_valid_d = 1'b1;
      m_data_d  = sum_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      slot_q    <= '0;
      w_q       <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      col_q     <= col_d;
      row_q     <= row_d;
      slot_q    <= slot_d;
      w_q       <= w_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      done_q    <= done_d;
    end
  end

  // Line buffer is never read before written, so it carries no reset
  always_ff @(posedge clk) begin
    if (accept_c) lb_q[slot_q][col_q][ch_q] <= s_data;
  end

endmodule

// File: tb/tb_stream_conv2d.sv
// Scoreboard bench for stream_conv2d: default instance plus a STRIDE=1 instance.
module tb_stream_conv2d;

  localparam int unsigned DW    = 8;
  localparam int unsigned K     = 2;
  localparam int unsigned CH    = 3;
  localparam int unsigned IMG   = 4;
  localparam int unsigned ACC_W = 20;
  localparam int unsigned NW    = K * K * CH;
  localparam int unsigned WF    = NW * DW;
  localparam int unsigned NBEAT = IMG * IMG * CH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [DW-1:0]     s_data;
  logic              s_valid;
  logic              s_ready;
  logic [WF-1:0]     w_flat;
  logic [ACC_W-1:0]  m_data;
  logic              m_valid;
  logic              m_ready;
  logic              frame_done;

  logic [DW-1:0]     s1_data;
  logic              s1_valid;
  logic              s1_ready;
  logic [ACC_W-1:0]  m1_data;
  logic              m1_valid;
  logic              m1_ready;
  logic              frame1_done;

  stream_conv2d #(.DATA_W(DW), .K(K), .CH(CH), .IMG(IMG), .STRIDE(2), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .w_flat(w_flat), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .frame_done(frame_done)
  );

  stream_conv2d #(.DATA_W(DW), .K(K), .CH(CH), .IMG(IMG), .STRIDE(1), .ACC_W(ACC_W)) u_dut1 (
    .clk(clk), .rst(rst), .s_data(s1_data), .s_valid(s1_valid), .s_ready(s1_ready),
    .w_flat(w_flat), .m_data(m1_data), .m_valid(m1_valid), .m_ready(m1_ready),
    .frame_done(frame1_done)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int fd_cnt = 0;
  int fd1_cnt = 0;
  int stall_n = 0;
  int sc = 0;
  logic xfer;

  logic [DW-1:0]    px [IMG][IMG][CH];
  logic [DW-1:0]    wt [NW];
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] exp1_q[$];

  function automatic longint sval(input logic [DW-1:0] v);
`ifdef STREAM_CONV_SIGNED_EN
    return longint'($signed(v));
`else
    return longint'(v);
`endif
  endfunction

  // Reference model indexed by output position
  task automatic build_expect(input int stride, input bit to1);
    int outn;
    longint s;
    outn = (int'(IMG) - int'(K)) / stride + 1;
    for (int orow = 0; orow < outn; orow++)
      for (int ocol = 0; ocol < outn; ocol++) begin
        s = 0;
        for (int kr = 0; kr < int'(K); kr++)
          for (int kc = 0; kc < int'(K); kc++)
            for (int c = 0; c < int'(CH); c++)
              s += sval(px[orow*stride+kr][ocol*stride+kc][c]) * sval(wt[(kr*int'(K)+kc)*int'(CH)+c]);
        if (to1) exp1_q.push_back(ACC_W'(s));
        else     exp_q.push_back(ACC_W'(s));
      end
  endtask

  task automatic fill(input bit rnd, input logic [DW-1:0] pv, input logic [DW-1:0] wv);
    for (int r = 0; r < int'(IMG); r++)
      for (int c = 0; c < int'(IMG); c++)
        for (int h = 0; h < int'(CH); h++)
          px[r][c][h] = rnd ? DW'($urandom) : pv;
    for (int i = 0; i < int'(NW); i++) wt[i] = rnd ? DW'($urandom) : wv;
  endtask

  task automatic load_w();
    for (int i = 0; i < int'(NW); i++) w_flat[i*DW +: DW] = wt[i];
  endtask

  // Streams the first nbeats of px; optionally corrupts w_flat after beat 0
  task automatic send0(input int nbeats, input bit scramble);
    int r, c, h, w;
    load_w();
    for (int b = 0; b < nbeats; b++) begin
      r = b / int'(IMG * CH);
      c = (b / int'(CH)) % int'(IMG);
      h = b % int'(CH);
      s_data  = px[r][c][h];
      s_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!s_ready && w < 1000) begin
        @(negedge clk);
        w++;
      end
      if (!s_ready) begin
        n_chk++;
        $display("FAIL send0_timeout: s_ready=%0b required 1 at beat %0d", s_ready, b);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (b == 0 && scramble)
        for (int i = 0; i < int'(NW); i++) w_flat[i*DW +: DW] = DW'($urandom);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_frame(input string name, input int target);
    int w;
    w = 0;
    while (fd_cnt < target && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (fd_cnt !== target) $display("FAIL %s_frame_done: count=%0d required %0d", name, fd_cnt, target);
    else n_pass++;
    n_chk++;
    if (exp_q.size() !== 0) $display("FAIL %s_outputs: pending=%0d required 0", name, exp_q.size());
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  // Downstream back-pressure: hold m_ready low for stall_n cycles per output
  initial begin
    m_ready = 1'b1;
    forever begin
      @(negedge clk);
      xfer = m_valid && m_ready;
      @(posedge clk);
      #1;
      if (xfer) sc = 0;
      if (stall_n > 0 && m_valid && sc < stall_n) begin
        m_ready = 1'b0;
        sc++;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Monitor for the default instance: scoreboard, hold-stability, stall s_ready, pulse width
  logic             hold_prev = 1'b0;
  logic [ACC_W-1:0] hold_data = '0;
  logic             fd_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      hold_prev = 1'b0;
      fd_prev   = 1'b0;
    end else begin
      if (frame_done) begin
        fd_cnt++;
        n_chk++;
        if (fd_prev) $display("FAIL frame_done_width: high=%0d cycles required 1", 2);
        else n_pass++;
      end
      fd_prev = frame_done;
      if (hold_prev) begin
        n_chk++;
        if (m_valid !== 1'b1 || m_data !== hold_data)
          $display("FAIL hold_stable: m_valid=%0b m_data=%0d required 1/%0d", m_valid, m_data, hold_data);
        else n_pass++;
      end
      if (m_valid && !m_ready) begin
        n_chk++;
        if (s_ready !== 1'b0) $display("FAIL stall_s_ready: s_ready=%0b required 0", s_ready);
        else n_pass++;
      end
      if (m_valid && m_ready) begin
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL out_unexpected: m_data=%0d required no output", m_data);
        else begin
          logic [ACC_W-1:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) $display("FAIL out_data: m_data=%0d required %0d", m_data, e);
          else n_pass++;
        end
      end
      hold_prev = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  // Monitor for the STRIDE=1 instance
  always @(negedge clk) begin
    if (rst) begin
      if (frame1_done) fd1_cnt++;
      if (m1_valid) begin
        n_chk++;
        if (exp1_q.size() == 0) $display("FAIL s1_unexpected: m_data=%0d required no output", m1_data);
        else begin
          logic [ACC_W-1:0] e;
          e = exp1_q.pop_front();
          if (m1_data !== e) $display("FAIL s1_data: m_data=%0d required %0d", m1_data, e);
          else n_pass++;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b0 || m_data !== '0 || frame_done !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL reset_outputs: v=%0b d=%0d fd=%0b rdy=%0b required 0/0/0/1", m_valid, m_data, frame_done, s_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_frame(input string name, input bit rnd, input logic [DW-1:0] pv,
                            input logic [DW-1:0] wv, input int stall, input bit scramble);
    int target;
    target  = fd_cnt + 1;
    stall_n = stall;
    fill(rnd, pv, wv);
    build_expect(2, 1'b0);
    send0(int'(NBEAT), scramble);
    wait_frame(name, target);
    stall_n = 0;
  endtask

  task automatic test_back_to_back();
    int target;
    target = fd_cnt + 2;
    fill(1'b1, '0, '0);
    build_expect(2, 1'b0);
    send0(int'(NBEAT), 1'b0);
    fill(1'b1, '0, '0);
    build_expect(2, 1'b0);
    send0(int'(NBEAT), 1'b0);
    wait_frame("back_to_back", target);
  endtask

  task automatic test_midframe_reset();
    int target;
    fill(1'b1, '0, '0);
    build_expect(2, 1'b0);
    send0(20, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b0 || m_data !== '0 || s_ready !== 1'b1 || frame_done !== 1'b0)
      $display("FAIL midreset_outputs: v=%0b d=%0d rdy=%0b fd=%0b required 0/0/1/0", m_valid, m_data, s_ready, frame_done);
    else n_pass++;
    n_chk++;
    if (exp_q.size() !== 3) $display("FAIL midreset_partial: pending=%0d required 3", exp_q.size());
    else n_pass++;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    target = fd_cnt + 1;
    fill(1'b1, '0, '0);
    build_expect(2, 1'b0);
    send0(int'(NBEAT), 1'b0);
    wait_frame("midreset_next", target);
  endtask

  task automatic test_stride1();
    int r, c, h, w;
    int target;
    target = fd1_cnt + 1;
    fill(1'b0, DW'(1), DW'(1));
    build_expect(1, 1'b1);
    load_w();
    for (int b = 0; b < int'(NBEAT); b++) begin
      r = b / int'(IMG * CH);
      c = (b / int'(CH)) % int'(IMG);
      h = b % int'(CH);
      s1_data  = px[r][c][h];
      s1_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!s1_ready && w < 1000) begin
        @(negedge clk);
        w++;
      end
      if (!s1_ready) begin
        n_chk++;
        $display("FAIL s1_timeout: s_ready=%0b required 1 at beat %0d", s1_ready, b);
        break;
      end
      @(posedge clk);
      #1;
    end
    s1_valid = 1'b0;
    w = 0;
    while (fd1_cnt < target && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (fd1_cnt !== target) $display("FAIL s1_frame_done: count=%0d required %0d", fd1_cnt, target);
    else n_pass++;
    n_chk++;
    if (exp1_q.size() !== 0) $display("FAIL s1_outputs: pending=%0d required 0", exp1_q.size());
    else n_pass++;
  endtask

  initial begin
    rst      = 1'b0;
    s_data   = '0;
    s_valid  = 1'b0;
    s1_data  = '0;
    s1_valid = 1'b0;
    m1_ready = 1'b1;
    w_flat   = '0;
    test_reset();
    test_frame("ones", 1'b0, DW'(1), DW'(1), 0, 1'b0);
    test_frame("max", 1'b0, DW'(255), DW'(255), 0, 1'b0);
    test_frame("stall", 1'b0, DW'(1), DW'(1), 5, 1'b0);
    test_frame("signed", 1'b0, DW'(8'hFF), DW'(2), 0, 1'b0);
    test_frame("wchange", 1'b1, '0, '0, 2, 1'b1);
    test_frame("random", 1'b1, '0, '0, 1, 1'b0);
    test_back_to_back();
    test_midframe_reset();
    test_stride1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_conv2d.md
STREAM_CONV2D -- requirements
Module: stream_conv2d

Interface
REQ-001 Parameter DATA_W, 8, pixel and weight width in bits.
REQ-002 Parameter K, 2, square kernel dimension; legal range 1..IMG.
REQ-003 Parameter CH, 3, channel count for both image and kernel.
REQ-004 Parameter IMG, 4, square image dimension.
REQ-005 Parameter STRIDE, 2, window step in rows and columns; legal range 1..K.
REQ-006 Parameter ACC_W, 20, accumulator and output width; must be at least 2*DATA_W + ceil(log2(K*K*CH)).
REQ-007 clk  input  1  clock; all state updates on the rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 s_data  input  DATA_W  stream sample; order is raster rows, then columns, channel innermost.
REQ-010 s_valid  input  1  s_data is valid.
REQ-011 s_ready  output  1  block accepts a sample this cycle.
REQ-012 w_flat  input  K*K*CH*DATA_W  weights, index ((kr*K+kc)*CH+ch), index 0 at the LSBs.
REQ-013 m_data  output  ACC_W  convolution result for one window.
REQ-014 m_valid  output  1  m_data is valid.
REQ-015 m_ready  input  1  downstream accepts m_data.
REQ-016 frame_done  output  1  one-cycle pulse after the last output of a frame is accepted.

Function
REQ-017 A beat is accepted when s_valid and s_ready are both 1; an output transfers when m_valid and m_ready are both 1.
REQ-018 Counters ch (0..CH-1), col (0..IMG-1) and row (0..IMG-1) advance once per accepted beat and wrap to 0 after the frame's last beat.
REQ-019 The line buffer holds K rows x IMG x CH samples as a circular row store; row r is written to slot r mod K; no sample is ever re-read from upstream.
REQ-020 w_flat is captured into an internal register on the first accepted beat of each frame; changes to w_flat mid-frame have no effect.
REQ-021 A window completes at pixel (r,c) when r>=K-1, c>=K-1, (r-K+1) mod STRIDE == 0 and (c-K+1) mod STRIDE == 0, evaluated on acceptance of channel CH-1.
REQ-022 m_data = sum over kr, kc, ch of w[kr][kc][ch] * px[r-K+1+kr][c-K+1+kc][ch], computed at full ACC_W width with no truncation.
REQ-023 m_valid asserts the cycle after the completing beat is accepted (latency 1); outputs follow raster order.
REQ-024 The number of outputs per frame is OUT*OUT, where OUT = (IMG-K)/STRIDE + 1 with floor division; trailing rows and columns that do not fit a window are ignored.
REQ-025 m_data and m_valid hold stable while m_valid=1 and m_ready=0.
REQ-026 s_ready = !m_valid || m_ready, so a new output can load in the same cycle the current one transfers; the block never drops or duplicates an output.
REQ-027 State machine:
  - IDLE: waiting for the first beat of a frame.
  - IDLE to RUN on the first accepted beat.
  - RUN to DRAIN on acceptance of the last beat (row=col=IMG-1, ch=CH-1).
  - DRAIN to IDLE when the final output transfers; s_ready=0 in DRAIN.
REQ-028 frame_done pulses high for exactly one cycle, on the cycle after the DRAIN-to-IDLE transition.
REQ-029 With K=1, every pixel produces an output, subject to the stride rule.

Reset
REQ-030 While rst=0: state is IDLE; all counters are 0; m_valid=0; m_data=0; frame_done=0; s_ready=1.
REQ-031 Asserting rst mid-frame discards the partial frame; the first beat accepted after release is pixel (0,0), channel 0.
REQ-032 Line-buffer contents are not reset; data is never consumed before it is written.

Configuration
REQ-033 Macro STREAM_CONV_SIGNED_EN selects the arithmetic mode.
  - Defined: s_data and weights are two's complement; products and sums are signed and sign-extended to ACC_W.
  - Undefined: all arithmetic is unsigned and zero-extended.

Verification
REQ-034 Defaults, all pixels 1, all weights 1, m_ready held at 1 -> 4 outputs of 12 each, then one frame_done pulse.
REQ-035 Defaults, all pixels 255, all weights 255 -> 4 outputs of 780300 each, with no overflow.
REQ-036 STRIDE=1, all pixels 1, all weights 1 -> 9 outputs of 12 each, in raster order.
REQ-037 Defaults, m_ready low for 5 cycles at each output -> s_ready=0 while stalled; output values match REQ-034; no loss or duplication.
REQ-038 Assert rst after 20 beats, then stream a full frame -> m_valid=0 during reset; the next frame yields exactly 4 correct outputs.
REQ-039 With STREAM_CONV_SIGNED_EN defined, pixels -1 (0xFF), weights 2 -> 4 outputs of -24 (two's complement at ACC_W).
